// File: rtl/dm_ram_pipe.sv
// Parametrised single-port MEM-stage data RAM with request/response handshake, post-reset clear and byte lanes.
// Optional per-lane even parity is enabled by defining DM_RAM_PARITY_EN.
module dm_ram_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 3072,
  parameter int OUT_REG        = 0,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_wbe,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_oob,
  output logic                  rsp_perr,
  output logic                  init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_L) state_d = ST_RUN;
    end
  end

  always_comb begin
    req_ready = (state_q == ST_RUN) && !rsta;
    init_done = (state_q == ST_RUN) && !rsta;
    clr_we    = (state_q == ST_CLEAR) && !rsta;
  end

  // RAM port: the clear sequence owns the port while it runs.
  logic              accept, in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [NB-1:0]     mem_wbe;
  logic [DATA_W-1:0] mem_wdata;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_L;

  always_comb begin
    mem_idx   = req_addr[IDX_W-1:0];
    mem_wbe   = '0;
    mem_wdata = req_wdata;
    if (clr_we) begin
      mem_idx   = clr_cnt_q[IDX_W-1:0];
      mem_wbe   = '1;
      mem_wdata = '0;
    end else if (accept && in_range) begin
      mem_wbe = req_wbe;
    end
  end

  logic [NB-1:0][7:0] mem [DEPTH];
  logic [NB-1:0][7:0] rd_word_q;

  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_wbe[i]) mem[mem_idx][i] <= mem_wdata[8*i +: 8];
    end
    if (accept) rd_word_q <= mem[mem_idx];
  end

  logic              v1_q, v1_d, have1_q, have1_d, oob1_q, oob1_d;
  logic [NB-1:0]     wbe1_q, wbe1_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d;

  always_comb begin
    v1_d     = accept;
    have1_d  = have1_q || accept;
    oob1_d   = oob1_q;
    wbe1_d   = wbe1_q;
    wdata1_d = wdata1_q;
    if (accept) begin
      oob1_d   = !in_range;
      wbe1_d   = in_range ? req_wbe : '0;
      wdata1_d = req_wdata;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      v1_q     <= 1'b0;
      have1_q  <= 1'b0;
      oob1_q   <= 1'b0;
      wbe1_q   <= '0;
      wdata1_q <= '0;
    end else begin
      v1_q     <= v1_d;
      have1_q  <= have1_d;
      oob1_q   <= oob1_d;
      wbe1_q   <= wbe1_d;
      wdata1_q <= wdata1_d;
    end
  end

  // Write-first merge happens after the RAM register so the array stays a plain block RAM.
  logic [DATA_W-1:0] merged, s1_rdata;
  logic              s1_perr;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[8*gi +: 8] = ((WRITE_FIRST != 0) && wbe1_q[gi]) ? wdata1_q[8*gi +: 8]
                                                                      : rd_word_q[gi];
    end
  endgenerate

  assign s1_rdata = (have1_q && !oob1_q) ? merged : '0;

`ifdef DM_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par_q, mem_par, calc_par;

  generate
    for (gi = 0; gi < NB; gi++) begin : g_par
      assign mem_par[gi]  = ^mem_wdata[8*gi +: 8];
      assign calc_par[gi] = ^rd_word_q[gi];
    end
  endgenerate

  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_wbe[i]) par_mem[mem_idx][i] <= mem_par[i];
    end
    if (accept) rd_par_q <= par_mem[mem_idx];
  end

  assign s1_perr = have1_q && !oob1_q && (rd_par_q != calc_par);
`else
  assign s1_perr = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              v2_q, v2_d, oob2_q, oob2_d, perr2_q, perr2_d;
      logic [DATA_W-1:0] rdata2_q, rdata2_d;

      always_comb begin
        v2_d     = v1_q;
        rdata2_d = rdata2_q;
        oob2_d   = oob2_q;
        perr2_d  = perr2_q;
        if (v1_q) begin
          rdata2_d = s1_rdata;
          oob2_d   = oob1_q;
          perr2_d  = s1_perr;
        end
      end

      always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
          v2_q     <= 1'b0;
          rdata2_q <= '0;
          oob2_q   <= 1'b0;
          perr2_q  <= 1'b0;
        end else begin
          v2_q     <= v2_d;
          rdata2_q <= rdata2_d;
          oob2_q   <= oob2_d;
          perr2_q  <= perr2_d;
        end
      end

      assign rsp_valid = v2_q;
      assign rsp_rdata = rdata2_q;
      assign rsp_oob   = oob2_q;
      assign rsp_perr  = perr2_q;
    end else begin : g_nreg
      assign rsp_valid = v1_q;
      assign rsp_rdata = s1_rdata;
      assign rsp_oob   = oob1_q;
      assign rsp_perr  = s1_perr;
    end
  endgenerate

endmodule
